// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and controller state encoding for the 1x1 convolution engine
package conv_pkg;
    localparam int LANES  = 8;
    localparam int ACC_W  = 32;
    localparam int PIXD_W = 64;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;
endpackage

// File: rtl/conv_1x1_ctrl_perf.sv
// conv_1x1_ctrl_perf: saturating busy and output-stall cycle counters
module conv_1x1_ctrl_perf (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_busy,
    input  logic        i_stall,
    output logic [31:0] o_busy_cycles,
    output logic [31:0] o_stall_cycles
);
    logic [31:0] r_busy, r_stall;
    // count qualifying cycles, clearing on reset or a new layer and holding at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_busy  <= '0;
            r_stall <= '0;
        end else begin
            r_busy  <= (i_busy && !(&r_busy)) ? r_busy + 32'd1 : r_busy;
            r_stall <= (i_stall && !(&r_stall)) ? r_stall + 32'd1 : r_stall;
        end
    end
    assign o_busy_cycles  = r_busy;
    assign o_stall_cycles = r_stall;
endmodule

// File: rtl/conv_1x1_ctrl.sv
// conv_1x1_ctrl: layer scheduler for one conv_1x1 datapath; CONV1X1_CTRL_PERF_EN adds perf counters
module conv_1x1_ctrl
    import conv_pkg::*;
#(
    parameter int CG_W  = 6,
    parameter int PIX_W = 16,
    parameter int PA_W  = 22,
    parameter int WA_W  = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CG_W-1:0]  i_cfg_cin_m1,
    input  logic [CG_W-1:0]  i_cfg_cout_m1,
    input  logic [PIX_W-1:0] i_cfg_pix_m1,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pix_rd_en,
    output logic [PA_W-1:0]  o_pix_addr,
    output logic             o_wgt_rd_en,
    output logic [WA_W-1:0]  o_wgt_addr,
    output logic [CG_W-1:0]  o_bias_addr,
    output logic             o_conv_valid_in,
    output logic             o_conv_last_channel,
    input  logic             i_conv_data_valid,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [PIX_W-1:0] o_out_pix,
    output logic [CG_W-1:0]  o_out_cog,
    output logic             o_err_unexpected
`ifdef CONV1X1_CTRL_PERF_EN
    ,
    output logic [31:0]      o_perf_busy_cycles,
    output logic [31:0]      o_perf_stall_cycles
`endif
);
    localparam int PW = (PIX_W + CG_W + 1 > PA_W) ? PIX_W + CG_W + 1 : PA_W;
    localparam int WW = (2 * CG_W + 1 > WA_W) ? 2 * CG_W + 1 : WA_W;

    state_t            r_state, w_next;
    logic [CG_W-1:0]   r_cin_m1, r_cout_m1, r_c, r_o;
    logic [PIX_W-1:0]  r_pix_m1, r_p;
    logic              r_valid_in, r_last, r_err;
    logic              w_accept, w_last_c, w_last_o, w_last_p, w_hs;
    logic [PW-1:0]     w_pix_full;
    logic [WW-1:0]     w_wgt_full;

    assign w_accept = (r_state == IDLE) && i_start;
    assign w_last_c = (r_c == r_cin_m1);
    assign w_last_o = (r_o == r_cout_m1);
    assign w_last_p = (r_p == r_pix_m1);
    assign w_hs     = (r_state == OUT) && i_out_ready;

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state: one input group per ISSUE cycle, one result handshake per tile
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? ISSUE : IDLE;
            ISSUE:   w_next = w_last_c ? WAIT : ISSUE;
            WAIT:    w_next = i_conv_data_valid ? OUT : WAIT;
            OUT:     w_next = !i_out_ready ? OUT : (w_last_o && w_last_p) ? DONE : ISSUE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // loop counters, latched config, datapath strobes and the sticky error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cin_m1   <= '0;
            r_cout_m1  <= '0;
            r_pix_m1   <= '0;
            r_c        <= '0;
            r_o        <= '0;
            r_p        <= '0;
            r_valid_in <= 1'b0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cin_m1  <= i_cfg_cin_m1;
                r_cout_m1 <= i_cfg_cout_m1;
                r_pix_m1  <= i_cfg_pix_m1;
                r_c       <= '0;
                r_o       <= '0;
                r_p       <= '0;
            end
            if (r_state == ISSUE) r_c <= w_last_c ? '0 : r_c + CG_W'(1);
            if (w_hs) begin
                r_o <= w_last_o ? '0 : r_o + CG_W'(1);
                if (w_last_o) r_p <= w_last_p ? '0 : r_p + PIX_W'(1);
            end
            r_valid_in <= (r_state == ISSUE);
            r_last     <= (r_state == ISSUE) && w_last_c;
            r_err      <= r_err | (i_conv_data_valid && (r_state != WAIT));
        end
    end

    // addresses are formed at full product width and truncated to the buffer width
    assign w_pix_full = PW'(r_p) * (PW'(r_cin_m1) + PW'(1)) + PW'(r_c);
    assign w_wgt_full = WW'(r_o) * (WW'(r_cin_m1) + WW'(1)) + WW'(r_c);

    assign o_busy              = (r_state != IDLE);
    assign o_done              = (r_state == DONE);
    assign o_pix_rd_en         = (r_state == ISSUE);
    assign o_wgt_rd_en         = (r_state == ISSUE);
    assign o_pix_addr          = w_pix_full[PA_W-1:0];
    assign o_wgt_addr          = w_wgt_full[WA_W-1:0];
    assign o_bias_addr         = r_o;
    assign o_conv_valid_in     = r_valid_in;
    assign o_conv_last_channel = r_last;
    assign o_out_valid         = (r_state == OUT);
    assign o_out_pix           = r_p;
    assign o_out_cog           = r_o;
    assign o_err_unexpected    = r_err;

`ifdef CONV1X1_CTRL_PERF_EN
    conv_1x1_ctrl_perf u_perf (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_clr          (w_accept),
        .i_busy         (o_busy),
        .i_stall        ((r_state == OUT) && !i_out_ready),
        .o_busy_cycles  (o_perf_busy_cycles),
        .o_stall_cycles (o_perf_stall_cycles)
    );
`endif
endmodule
